dot_mv_engine: RTL and testbench

- Parametrised matrix-vector successor to the single-neuron dot-product accelerator.
- Computes OUT_LEN neurons: out[j] = act(bias[j] + sum_i W[j][i]*in[i]) in signed fixed point.
- Reads weights and biases over the SDRAM master and input activations over the SRAM master; writes output activations back to SRAM through master2.
- Configured and started by the CPU through the Avalon slave; optional ReLU.

---
 rtl/dot_mv_engine.sv | 273 +++++++++++++++++++++++++++
 tb/tb_dot_mv_engine.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_mv_engine.sv
// Matrix-vector fixed-point engine: out[j] = act(bias[j] + sum_i W[j][i]*in[i]).
// Weights/biases stream from SDRAM, activations from/to SRAM, CPU config via slave.
module dot_mv_engine #(
  parameter int DW   = 32,
  parameter int FRAC = 16,
  parameter int ACCW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          slave_waitrequest,
  input  logic [3:0]    slave_address,
  input  logic          slave_read,
  output logic [31:0]   slave_readdata,
  input  logic          slave_write,
  input  logic [31:0]   slave_writedata,
  input  logic          master_waitrequest,
  output logic [31:0]   master_address,
  output logic          master_read,
  input  logic [DW-1:0] master_readdata,
  input  logic          master_readdatavalid,
  output logic          master_write,
  output logic [DW-1:0] master_writedata,
  input  logic          master2_waitrequest,
  output logic [31:0]   master2_address,
  output logic          master2_read,
  input  logic [DW-1:0] master2_readdata,
  input  logic          master2_readdatavalid,
  output logic          master2_write,
  output logic [DW-1:0] master2_writedata
);

  typedef enum logic [2:0] {
    IDLE, RD_BIAS, RD_PAIR, MAC, WR_OUT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0] bias_base_q, bias_base_d;
  logic [31:0] w_base_q, w_base_d;
  logic [31:0] in_base_q, in_base_d;
  logic [31:0] out_base_q, out_base_d;
  logic [31:0] in_len_q, in_len_d;
  logic [31:0] out_len_q, out_len_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] i_q, i_d;
  logic [31:0] j_q, j_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [DW-1:0] last_q, last_d;
  logic [DW-1:0] w_q, w_d;
  logic [DW-1:0] x_q, x_d;
  logic m_req_q, m_req_d;
  logic s_req_q, s_req_d;
  logic w_got_q, w_got_d;
  logic x_got_q, x_got_d;

  logic busy;
  logic cfg_wr;
  logic start;
  logic [31:0] widx;
  logic [DW-1:0] res;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] bias_ext;

  assign busy = (state_q == RD_BIAS) || (state_q == RD_PAIR) ||
                (state_q == MAC) || (state_q == WR_OUT);
  assign cfg_wr = slave_write && !busy;
  assign start = cfg_wr && (slave_address == 4'd0);

  assign widx = j_q * in_len_q + i_q;
  assign prod = $signed(w_q) * $signed(x_q);
  assign prod_ext = ACCW'(prod);
  assign bias_ext = ACCW'($signed(master_readdata));

  // Floor truncation falls out of dropping the low FRAC bits of a 2's-complement value
  assign res = (ctrl_q[0] && acc_q[ACCW-1]) ? '0 : acc_q[FRAC+DW-1:FRAC];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bias_base_q <= '0;
      w_base_q    <= '0;
      in_base_q   <= '0;
      out_base_q  <= '0;
      in_len_q    <= '0;
      out_len_q   <= '0;
      ctrl_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      last_q      <= '0;
      w_q         <= '0;
      x_q         <= '0;
      m_req_q     <= 1'b0;
      s_req_q     <= 1'b0;
      w_got_q     <= 1'b0;
      x_got_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bias_base_q <= bias_base_d;
      w_base_q    <= w_base_d;
      in_base_q   <= in_base_d;
      out_base_q  <= out_base_d;
      in_len_q    <= in_len_d;
      out_len_q   <= out_len_d;
      ctrl_q      <= ctrl_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      last_q      <= last_d;
      w_q         <= w_d;
      x_q         <= x_d;
      m_req_q     <= m_req_d;
      s_req_q     <= s_req_d;
      w_got_q     <= w_got_d;
      x_got_q     <= x_got_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bias_base_d = bias_base_q;
    w_base_d    = w_base_q;
    in_base_d   = in_base_q;
    out_base_d  = out_base_q;
    in_len_d    = in_len_q;
    out_len_d   = out_len_q;
    ctrl_d      = ctrl_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    last_d      = last_q;
    w_d         = w_q;
    x_d         = x_q;
    m_req_d     = m_req_q;
    s_req_d     = s_req_q;
    w_got_d     = w_got_q;
    x_got_d     = x_got_q;

    if (cfg_wr) begin
      unique case (1'b1)
        slave_address == 4'd1: bias_base_d = slave_writedata;
        slave_address == 4'd2: w_base_d    = slave_writedata;
        slave_address == 4'd3: in_base_d   = slave_writedata;
        slave_address == 4'd4: out_base_d  = slave_writedata;
        slave_address == 4'd5: in_len_d    = slave_writedata;
        slave_address == 4'd6: out_len_d   = slave_writedata;
        slave_address == 4'd7: ctrl_d      = slave_writedata;
        default: ;
      endcase
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          j_d = '0;
          if (out_len_q == '0) begin
            state_d = DONE;
          end else begin
            state_d = RD_BIAS;
            m_req_d = 1'b1;
          end
        end else if (state_q == DONE && slave_read &&
                     slave_address == 4'd0) begin
          state_d = IDLE;
        end
      end
      RD_BIAS: begin
        if (m_req_q) begin
          if (!master_waitrequest) m_req_d = 1'b0;
        end else if (master_readdatavalid) begin
          acc_d = bias_ext <<< FRAC;
          i_d   = '0;
          if (in_len_q != '0) begin
            state_d = RD_PAIR;
            m_req_d = 1'b1;
            s_req_d = 1'b1;
            w_got_d = 1'b0;
            x_got_d = 1'b0;
          end else begin
            state_d = WR_OUT;
          end
        end
      end
      RD_PAIR: begin
        if (m_req_q && !master_waitrequest) m_req_d = 1'b0;
        if (s_req_q && !master2_waitrequest) s_req_d = 1'b0;
        if (!m_req_q && !w_got_q && master_readdatavalid) begin
          w_d     = master_readdata;
          w_got_d = 1'b1;
        end
        if (!s_req_q && !x_got_q && master2_readdatavalid) begin
          x_d     = master2_readdata;
          x_got_d = 1'b1;
        end
        if (w_got_d && x_got_d) state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        i_d   = i_q + 32'd1;
        if (i_d < in_len_q) begin
          state_d = RD_PAIR;
          m_req_d = 1'b1;
          s_req_d = 1'b1;
          w_got_d = 1'b0;
          x_got_d = 1'b0;
        end else begin
          state_d = WR_OUT;
        end
      end
      WR_OUT: begin
        if (!master2_waitrequest) begin
          last_d = res;
          j_d    = j_q + 32'd1;
          if (j_d < out_len_q) begin
            state_d = RD_BIAS;
            m_req_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slave_readdata = '0;
    case (slave_address)
      4'd0: slave_readdata = 32'(last_q);
      4'd1: slave_readdata = bias_base_q;
      4'd2: slave_readdata = w_base_q;
      4'd3: slave_readdata = in_base_q;
      4'd4: slave_readdata = out_base_q;
      4'd5: slave_readdata = in_len_q;
      4'd6: slave_readdata = out_len_q;
      4'd7: slave_readdata = ctrl_q;
      default: slave_readdata = '0;
    endcase
  end

  assign slave_waitrequest = busy && (slave_read || slave_write);

  assign master_write     = 1'b0;
  assign master_writedata = '0;

  always_comb begin
    master_read     = 1'b0;
    master_address  = '0;
    master2_read    = 1'b0;
    master2_write   = 1'b0;
    master2_address = '0;
    master2_writedata = '0;
    if (state_q == RD_BIAS && m_req_q) begin
      master_read    = 1'b1;
      master_address = bias_base_q + {j_q[29:0], 2'b00};
    end
    if (state_q == RD_PAIR && m_req_q) begin
      master_read    = 1'b1;
      master_address = w_base_q + {widx[29:0], 2'b00};
    end
    if (state_q == RD_PAIR && s_req_q) begin
      master2_read    = 1'b1;
      master2_address = in_base_q + {i_q[29:0], 2'b00};
    end
    if (state_q == WR_OUT) begin
      master2_write     = 1'b1;
      master2_address   = out_base_q + {j_q[29:0], 2'b00};
      master2_writedata = res;
    end
  end

endmodule

// File: tb/tb_dot_mv_engine.sv
// Scoreboard bench for dot_mv_engine: directed vectors, bus models with
// optional random stalls and latency, decoupled output-write monitor.
module tb_dot_mv_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 1'b0;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master2_waitrequest = 1'b0;
  logic [31:0] master2_address;
  logic        master2_read;
  logic [31:0] master2_readdata = '0;
  logic        master2_readdatavalid = 1'b0;
  logic        master2_write;
  logic [31:0] master2_writedata;

  always #5 clk = ~clk;

  dot_mv_engine dut (
    .clk(clk), .rst_n(rst_n),
    .slave_waitrequest(slave_waitrequest),
    .slave_address(slave_address),
    .slave_read(slave_read),
    .slave_readdata(slave_readdata),
    .slave_write(slave_write),
    .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest),
    .master_address(master_address),
    .master_read(master_read),
    .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_write(master_write),
    .master_writedata(master_writedata),
    .master2_waitrequest(master2_waitrequest),
    .master2_address(master2_address),
    .master2_read(master2_read),
    .master2_readdata(master2_readdata),
    .master2_readdatavalid(master2_readdatavalid),
    .master2_write(master2_write),
    .master2_writedata(master2_writedata)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int traffic = 0;
  bit stress = 1'b0;

  logic [31:0] sd [0:255];
  logic [31:0] sr [0:255];
  logic [31:0] m_dat[$];
  int          m_rdy[$];
  logic [31:0] s_dat[$];
  int          s_rdy[$];
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  // Bus models: pick this cycle's stalls, return due data, accept requests
  always @(negedge clk) begin
    cyc++;
    master_waitrequest  = stress ? 1'($urandom_range(0, 1)) : 1'b0;
    master2_waitrequest = stress ? 1'($urandom_range(0, 1)) : 1'b0;
    if (m_rdy.size() > 0 && m_rdy[0] <= cyc) begin
      master_readdatavalid = 1'b1;
      master_readdata = m_dat.pop_front();
      void'(m_rdy.pop_front());
    end else begin
      master_readdatavalid = 1'b0;
      master_readdata = '0;
    end
    if (s_rdy.size() > 0 && s_rdy[0] <= cyc) begin
      master2_readdatavalid = 1'b1;
      master2_readdata = s_dat.pop_front();
      void'(s_rdy.pop_front());
    end else begin
      master2_readdatavalid = 1'b0;
      master2_readdata = '0;
    end
    if (master_read && !master_waitrequest) begin
      m_dat.push_back(sd[master_address[9:2]]);
      m_rdy.push_back(cyc + (stress ? int'($urandom_range(1, 5)) : 1));
      traffic++;
    end
    if (master2_read && !master2_waitrequest) begin
      s_dat.push_back(sr[master2_address[9:2]]);
      s_rdy.push_back(cyc + (stress ? int'($urandom_range(1, 5)) : 1));
      traffic++;
    end
    if (master2_write && !master2_waitrequest) begin
      sr[master2_address[9:2]] = master2_writedata;
      traffic++;
    end
  end

  logic        prev_m = 1'b0;
  logic [31:0] prev_ma = '0;
  logic        prev_s = 1'b0;
  logic [31:0] prev_sa = '0;

  // Monitor: output writes against scoreboard, stalled strobes must hold
  always @(negedge clk) begin
    logic [63:0] e;
    #1;
    if (rst_n && master2_write && !master2_waitrequest) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h",
                 master2_address, master2_writedata);
      end else begin
        e = exp_q.pop_front();
        chk("out_addr", master2_address, e[63:32]);
        chk("out_data", master2_writedata, e[31:0]);
      end
    end
    if (prev_m) begin
      chk("m_hold", {master_read, master_address}  == {1'b1, prev_ma}
          ? 32'd1 : 32'd0, 32'd1);
    end
    if (prev_s) begin
      chk("m2_hold", {master2_read, master2_address} == {1'b1, prev_sa}
          ? 32'd1 : 32'd0, 32'd1);
    end
    prev_m  = rst_n && master_read && master_waitrequest;
    prev_ma = master_address;
    prev_s  = rst_n && master2_read && master2_waitrequest;
    prev_sa = master2_address;
  end

  task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d,
                        output int stalls);
    stalls = 0;
    @(negedge clk);
    slave_address = a;
    slave_writedata = d;
    slave_write = 1'b1;
    #1;
    while (slave_waitrequest && stalls < 3000) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 3000) begin
      total++;
      bad++;
      $display("FAIL wr_timeout addr=%0d got=stalled want=accept", a);
    end
    @(posedge clk);
    #1;
    slave_write = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    int s;
    cpu_wr(a, d, s);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    slave_address = a;
    slave_read = 1'b1;
    #1;
    while (slave_waitrequest && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL rd_timeout addr=%0d got=stalled want=accept", a);
    end
    d = slave_readdata;
    @(posedge clk);
    #1;
    slave_read = 1'b0;
  endtask

  task automatic cfg(input logic [31:0] il, input logic [31:0] ol,
                     input logic [31:0] ctl);
    wr(4'd1, 32'h100);
    wr(4'd2, 32'h200);
    wr(4'd3, 32'h40);
    wr(4'd4, 32'h80);
    wr(4'd5, il);
    wr(4'd6, ol);
    wr(4'd7, ctl);
  endtask

  task automatic load_t1();
    sd[64] = 32'h8000;
    sd[128] = 32'h10000;
    sd[129] = 32'h20000;
    sd[130] = 32'h8000;
    sr[16] = 32'h10000;
    sr[17] = 32'h10000;
    sr[18] = 32'h20000;
  endtask

  task automatic load_t2();
    sd[64] = 32'h0;
    sd[65] = 32'h0;
    sd[128] = 32'h10000;
    sd[129] = 32'h0;
    sd[130] = 32'h0;
    sd[131] = 32'hFFFF0000;
    sr[16] = 32'h30000;
    sr[17] = 32'h20000;
  endtask

  task automatic run(input string nm, input logic [31:0] want_last);
    logic [31:0] v;
    wr(4'd0, 32'h1);
    rd(4'd0, v);
    chk(nm, v, want_last);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int s;
    int t0;
    for (int k = 0; k < 256; k++) begin
      sd[k] = '0;
      sr[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    rd(4'd0, v); chk("rst_last", v, 32'h0);
    rd(4'd1, v); chk("rst_bias_base", v, 32'h0);
    rd(4'd6, v); chk("rst_out_len", v, 32'h0);

    for (int pass = 0; pass < 2; pass++) begin
      stress = (pass == 1);
      load_t1();
      cfg(32'd3, 32'd1, 32'd0);
      rd(4'd5, v); chk("cfg_in_len", v, 32'd3);
      rd(4'd2, v); chk("cfg_w_base", v, 32'h200);
      exp_q.push_back({32'h80, 32'h48000});
      run("t1_last", 32'h48000);
      chk("t1_sram", sr[32], 32'h48000);

      load_t2();
      cfg(32'd2, 32'd2, 32'd1);
      exp_q.push_back({32'h80, 32'h30000});
      exp_q.push_back({32'h84, 32'h0});
      run("t2_relu_last", 32'h0);

      wr(4'd7, 32'd0);
      exp_q.push_back({32'h80, 32'h30000});
      exp_q.push_back({32'h84, 32'hFFFE0000});
      run("t2_norelu_last", 32'hFFFE0000);
    end
    stress = 1'b0;

    sd[64] = 32'h10000;
    sd[65] = 32'hFFFF0000;
    cfg(32'd0, 32'd2, 32'd1);
    exp_q.push_back({32'h80, 32'h10000});
    exp_q.push_back({32'h84, 32'h0});
    run("inlen0_relu_last", 32'h0);
    wr(4'd7, 32'd0);
    exp_q.push_back({32'h80, 32'h10000});
    exp_q.push_back({32'h84, 32'hFFFF0000});
    run("inlen0_last", 32'hFFFF0000);

    t0 = traffic;
    wr(4'd6, 32'd0);
    run("outlen0_last", 32'hFFFF0000);
    chk("outlen0_traffic", 32'(traffic), 32'(t0));

    load_t1();
    cfg(32'd3, 32'd1, 32'd0);
    exp_q.push_back({32'h80, 32'h48000});
    wr(4'd0, 32'h1);
    cpu_wr(4'd2, 32'h300, s);
    chk("busy_stalled", (s > 3) ? 32'd1 : 32'd0, 32'd1);
    rd(4'd2, v); chk("busy_w_base", v, 32'h300);
    rd(4'd0, v); chk("busy_last", v, 32'h48000);
    wr(4'd2, 32'h200);

    wr(4'd5, 32'd3);
    wr(4'd6, 32'd1);
    wr(4'd0, 32'h1);
    s = 0;
    @(negedge clk);
    #1;
    while (!master2_read && s < 200) begin
      @(negedge clk);
      #1;
      s++;
    end
    chk("reach_rd_pair", {31'd0, master2_read}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_strobes", {29'd0, master_read, master2_read, master2_write},
        32'd0);
    chk("rst_maddr", master_address, 32'h0);
    rst_n = 1'b1;
    for (int a = 1; a < 8; a++) begin
      rd(4'(a), v);
      chk($sformatf("rst_reg%0d", a), v, 32'h0);
    end
    rd(4'd0, v); chk("rst_mid_last", v, 32'h0);
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
